// File: rtl/fc_psum_accumulator.sv
// Accumulates LANES-wide signed partial-sum beats from fc_pe onto a per-lane bias,
// then requantises (shift, optional ReLU, saturate) and hands off over valid/ready.
module fc_psum_accumulator #(
   parameter int unsigned LANES = 7,
   parameter int unsigned IN_W  = 16,
   parameter int unsigned ACC_W = 32,
   parameter int unsigned OUT_W = 16,
   parameter int unsigned CNT_W = 10
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [CNT_W-1:0]       cfg_beats,
   input  logic [3:0]             cfg_shift,
   input  logic                   cfg_relu,
   input  logic [LANES*IN_W-1:0]  bias_in,
   input  logic [LANES*IN_W-1:0]  psum_in,
   input  logic                   psum_valid,
   output logic                   psum_ready,
   output logic [LANES*OUT_W-1:0] out_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [CNT_W-1:0]       beat_cnt,
   output logic                   err_cfg
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ACC  = 2'd1,
      S_OUT  = 2'd2
   } state_t;

   localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

   state_t                    r_state;
   logic                      r_psum_ready;
   logic                      r_out_valid;
   logic [LANES*OUT_W-1:0]    r_out_data;
   logic [CNT_W-1:0]          r_beat_cnt;
   logic [CNT_W-1:0]          r_n;
   logic [3:0]                r_shift;
   logic                      r_relu;
   logic                      r_err;
   logic signed [ACC_W-1:0]   r_acc [LANES];

   logic                      w_accept;
   logic [CNT_W-1:0]          w_n_eff;
   logic [CNT_W-1:0]          w_cnt_inc;
   logic [3:0]                w_shift_sel;
   logic                      w_relu_sel;
   logic signed [ACC_W-1:0]   w_acc_next [LANES];
   logic [LANES*OUT_W-1:0]    w_q;

   function automatic logic signed [ACC_W-1:0] sext_in(input logic [IN_W-1:0] v);
      return {{(ACC_W-IN_W){v[IN_W-1]}}, v};
   endfunction

   function automatic logic [OUT_W-1:0] requant(input logic signed [ACC_W-1:0] a,
                                                input logic [3:0] sh,
                                                input logic relu);
      logic signed [ACC_W-1:0] s;
      s = a >>> sh;
      if (relu && s[ACC_W-1]) begin
         s = '0;
      end
      if (s > SAT_MAX) begin
         s = SAT_MAX;
      end else if (s < SAT_MIN) begin
         s = SAT_MIN;
      end
      return s[OUT_W-1:0];
   endfunction

   assign w_accept  = psum_valid && r_psum_ready;
   assign w_n_eff   = (cfg_beats == '0) ? CNT_W'(1) : cfg_beats;
   assign w_cnt_inc = r_beat_cnt + CNT_W'(1);

   // First beat of a group uses live config/bias because latching happens on the same edge.
   always_comb begin
      w_shift_sel = r_shift;
      w_relu_sel  = r_relu;
      w_q         = '0;
      if (r_state == S_IDLE) begin
         w_shift_sel = cfg_shift;
         w_relu_sel  = cfg_relu;
      end
      for (int i = 0; i < LANES; i++) begin
         if (r_state == S_IDLE) begin
            w_acc_next[i] = sext_in(bias_in[i*IN_W +: IN_W]) + sext_in(psum_in[i*IN_W +: IN_W]);
         end else begin
            w_acc_next[i] = r_acc[i] + sext_in(psum_in[i*IN_W +: IN_W]);
         end
         w_q[i*OUT_W +: OUT_W] = requant(w_acc_next[i], w_shift_sel, w_relu_sel);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_psum_ready <= 1'b1;
         r_out_valid  <= 1'b0;
         r_out_data   <= '0;
         r_beat_cnt   <= '0;
         r_n          <= '0;
         r_shift      <= '0;
         r_relu       <= 1'b0;
         r_err        <= 1'b0;
         for (int i = 0; i < LANES; i++) begin
            r_acc[i] <= '0;
         end
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_n        <= w_n_eff;
                  r_shift    <= cfg_shift;
                  r_relu     <= cfg_relu;
                  r_beat_cnt <= CNT_W'(1);
                  if (cfg_beats == '0) begin
                     r_err <= 1'b1;
                  end
                  for (int i = 0; i < LANES; i++) begin
                     r_acc[i] <= w_acc_next[i];
                  end
                  if (w_n_eff == CNT_W'(1)) begin
                     r_state      <= S_OUT;
                     r_psum_ready <= 1'b0;
                     r_out_valid  <= 1'b1;
                     r_out_data   <= w_q;
                  end else begin
                     r_state <= S_ACC;
                  end
               end
            end
            S_ACC: begin
               if (w_accept) begin
                  r_beat_cnt <= w_cnt_inc;
                  for (int i = 0; i < LANES; i++) begin
                     r_acc[i] <= w_acc_next[i];
                  end
                  if (w_cnt_inc == r_n) begin
                     r_state      <= S_OUT;
                     r_psum_ready <= 1'b0;
                     r_out_valid  <= 1'b1;
                     r_out_data   <= w_q;
                  end
               end
            end
            S_OUT: begin
               if (out_ready) begin
                  r_state      <= S_IDLE;
                  r_psum_ready <= 1'b1;
                  r_out_valid  <= 1'b0;
                  r_beat_cnt   <= '0;
               end
            end
            default: begin
               r_state      <= S_IDLE;
               r_psum_ready <= 1'b1;
               r_out_valid  <= 1'b0;
            end
         endcase
      end
   end

   assign psum_ready = r_psum_ready;
   assign out_valid  = r_out_valid;
   assign out_data   = r_out_data;
   assign beat_cnt   = r_beat_cnt;
   assign err_cfg    = r_err;

endmodule

// File: tb/tb_fc_psum_accumulator.sv
// Scoreboard bench for fc_psum_accumulator: a behavioural group model pushes expected
// bundles on each completed group; a monitor pops them on every output handshake.
module tb_fc_psum_accumulator;

   logic         clk = 1'b0;
   logic         rst;
   logic [9:0]   cfg_beats;
   logic [3:0]   cfg_shift;
   logic         cfg_relu;
   logic [111:0] bias_in;
   logic [111:0] psum_in;
   logic         psum_valid;
   logic         psum_ready;
   logic [111:0] out_data;
   logic         out_valid;
   logic         out_ready;
   logic [9:0]   beat_cnt;
   logic         err_cfg;

   int n_checks = 0;
   int n_fail   = 0;

   logic [111:0] exp_q [$];

   // group model state
   int     m_cnt = 0;
   int     m_n;
   int     m_shift;
   bit     m_relu;
   longint m_acc [7];

   fc_psum_accumulator dut (
      .clk        (clk),
      .rst        (rst),
      .cfg_beats  (cfg_beats),
      .cfg_shift  (cfg_shift),
      .cfg_relu   (cfg_relu),
      .bias_in    (bias_in),
      .psum_in    (psum_in),
      .psum_valid (psum_valid),
      .psum_ready (psum_ready),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .beat_cnt   (beat_cnt),
      .err_cfg    (err_cfg)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [111:0] mk(input int l0, input int l1, input int l2, input int l3,
                                       input int l4, input int l5, input int l6);
      return {16'(l6), 16'(l5), 16'(l4), 16'(l3), 16'(l2), 16'(l1), 16'(l0)};
   endfunction

   function automatic longint lane(input logic [111:0] v, input int i);
      logic signed [15:0] x;
      x = v[i*16 +: 16];
      return longint'(x);
   endfunction

   function automatic logic [15:0] m_q(input longint a, input int sh, input bit relu);
      longint s;
      s = a >>> sh;
      if (relu && s < 0) s = 0;
      if (s > 32767) s = 32767;
      if (s < -32768) s = -32768;
      return 16'(s);
   endfunction

   // Called for a beat that the DUT accepts at the coming edge, with cfg/bias as driven.
   task automatic model_accept(input logic [111:0] p);
      logic [111:0] e;
      if (m_cnt == 0) begin
         m_n     = (cfg_beats == 10'd0) ? 1 : int'(cfg_beats);
         m_shift = int'(cfg_shift);
         m_relu  = cfg_relu;
         for (int i = 0; i < 7; i++) m_acc[i] = lane(bias_in, i) + lane(p, i);
         m_cnt = 1;
      end else begin
         for (int i = 0; i < 7; i++) m_acc[i] += lane(p, i);
         m_cnt++;
      end
      if (m_cnt == m_n) begin
         for (int i = 0; i < 7; i++) e[i*16 +: 16] = m_q(m_acc[i], m_shift, m_relu);
         exp_q.push_back(e);
         m_cnt = 0;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_beat(input logic [111:0] p);
      int g;
      g = 0;
      psum_in    = p;
      psum_valid = 1'b1;
      while (!psum_ready && g < 100) begin
         tick();
         g++;
      end
      if (!psum_ready) begin
         check_eq("ready_timeout", 128'(psum_ready), 128'(1));
         psum_valid = 1'b0;
         return;
      end
      model_accept(p);
      tick();
      psum_valid = 1'b0;
   endtask

   task automatic set_cfg(input int beats, input int sh, input bit relu, input logic [111:0] b);
      cfg_beats = 10'(beats);
      cfg_shift = 4'(sh);
      cfg_relu  = relu;
      bias_in   = b;
   endtask

   // scoreboard monitor: compare on every output handshake
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check_eq("unexpected_out", 128'(out_data), 128'(0) - 128'(1));
         end else begin
            check_eq("sb_out_data", 128'(out_data), 128'(exp_q.pop_front()));
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

   logic [111:0] exp_hold;
   bit           pat [6] = '{1, 0, 0, 1, 0, 1};

   initial begin
      rst        = 1'b1;
      psum_valid = 1'b0;
      psum_in    = '0;
      out_ready  = 1'b1;
      set_cfg(1, 0, 0, '0);
      repeat (3) tick();
      rst = 1'b0;
      tick();

      // reset state
      check_eq("rst_ready",    128'(psum_ready), 128'(1));
      check_eq("rst_valid",    128'(out_valid),  128'(0));
      check_eq("rst_beat_cnt", 128'(beat_cnt),   128'(0));
      check_eq("rst_err",      128'(err_cfg),    128'(0));
      check_eq("rst_data",     128'(out_data),   128'(0));

      // single beat, one-cycle latency
      set_cfg(1, 0, 0, '0);
      send_beat(mk(1, -2, 3, -4, 5, -6, 7));
      check_eq("t1_valid", 128'(out_valid),  128'(1));
      check_eq("t1_data",  128'(out_data),   128'(mk(1, -2, 3, -4, 5, -6, 7)));
      check_eq("t1_ready", 128'(psum_ready), 128'(0));
      tick();
      check_eq("t1_valid_drop", 128'(out_valid),  128'(0));
      check_eq("t1_ready_back", 128'(psum_ready), 128'(1));
      check_eq("t1_cnt_clear",  128'(beat_cnt),   128'(0));

      // multi-beat with bias and shift
      set_cfg(4, 2, 0, mk(10, 0, 0, 0, 0, 0, 0));
      for (int k = 1; k <= 4; k++) begin
         send_beat(mk(100, k, -k, 0, 0, 0, 0));
         check_eq($sformatf("t2_cnt%0d", k), 128'(beat_cnt), 128'(k));
      end
      check_eq("t2_ready", 128'(psum_ready), 128'(0));
      check_eq("t2_lane0", 128'(out_data[15:0]), 128'(16'd102));
      tick();

      // ReLU on negative sum
      set_cfg(2, 0, 1, '0);
      repeat (2) send_beat(mk(-500, 0, 0, 0, 0, 0, 0));
      check_eq("t3_relu_lane0", 128'(out_data[15:0]), 128'(16'd0));
      tick();
      // positive / negative saturation
      set_cfg(3, 0, 0, '0);
      repeat (3) send_beat(mk(0, 30000, -30000, 0, 0, 0, 0));
      check_eq("t3_sat_pos", 128'(out_data[31:16]), 128'(16'h7fff));
      check_eq("t3_sat_neg", 128'(out_data[47:32]), 128'(16'h8000));
      tick();

      // backpressure: output held, new bundle waits, fresh bias used afterwards
      out_ready = 1'b0;
      set_cfg(1, 0, 0, mk(5, 5, 5, 5, 5, 5, 5));
      send_beat(mk(1, 2, 3, 4, 5, 6, 7));
      exp_hold   = mk(6, 7, 8, 9, 10, 11, 12);
      set_cfg(1, 0, 0, mk(7, 7, 7, 7, 7, 7, 7));
      psum_in    = mk(-1, -1, -1, -1, -1, -1, -1);
      psum_valid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         check_eq("t4_hold_data",  128'(out_data),   128'(exp_hold));
         check_eq("t4_hold_ready", 128'(psum_ready), 128'(0));
         check_eq("t4_hold_valid", 128'(out_valid),  128'(1));
         check_eq("t4_hold_cnt",   128'(beat_cnt),   128'(1));
         tick();
      end
      out_ready = 1'b1;
      send_beat(mk(-1, -1, -1, -1, -1, -1, -1));
      check_eq("t4_fresh_bias", 128'(out_data), 128'(mk(6, 6, 6, 6, 6, 6, 6)));
      tick();

      // gaps and mid-group config change
      set_cfg(3, 0, 0, mk(1, 0, 0, 0, 0, 0, 0));
      for (int k = 0; k < 6; k++) begin
         psum_valid = pat[k];
         psum_in    = mk(k + 1, 10 * k, 0, 0, 0, 0, -k);
         if (psum_valid && psum_ready) model_accept(psum_in);
         tick();
         cfg_beats = 10'd7;
      end
      psum_valid = 1'b0;
      check_eq("t5_valid", 128'(out_valid), 128'(1));
      check_eq("t5_cnt",   128'(beat_cnt),  128'(3));
      check_eq("t5_lane0", 128'(out_data[15:0]), 128'(16'd12));
      tick();

      // reset mid-group discards partial result
      set_cfg(4, 0, 0, mk(3, 3, 3, 3, 3, 3, 3));
      repeat (2) send_beat(mk(50, 50, 50, 50, 50, 50, 50));
      rst   = 1'b1;
      m_cnt = 0;
      exp_q.delete();
      tick();
      check_eq("t6_rst_valid", 128'(out_valid), 128'(0));
      check_eq("t6_rst_cnt",   128'(beat_cnt),  128'(0));
      rst = 1'b0;
      tick();
      check_eq("t6_no_out", 128'(out_valid), 128'(0));
      set_cfg(1, 0, 0, mk(3, -3, 3, -3, 3, -3, 3));
      send_beat('0);
      check_eq("t6_bias_only", 128'(out_data), 128'(mk(3, -3, 3, -3, 3, -3, 3)));
      tick();

      // cfg_beats == 0 treated as one beat, sticky error
      set_cfg(0, 0, 0, '0);
      send_beat(mk(9, 8, 7, 6, 5, 4, 3));
      check_eq("t7_err",   128'(err_cfg),   128'(1));
      check_eq("t7_valid", 128'(out_valid), 128'(1));
      tick();
      set_cfg(2, 1, 0, '0);
      repeat (2) send_beat(mk(4, 4, 4, 4, 4, 4, 4));
      tick();
      check_eq("t7_err_sticky", 128'(err_cfg), 128'(1));
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      check_eq("t7_err_cleared", 128'(err_cfg), 128'(0));

      repeat (2) tick();
      check_eq("sb_empty", 128'(exp_q.size()), 128'(0));

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
